// File: rtl/can_stuffing.sv
// Transmit-side CAN bit stuffer: after RUN_LENGTH equal bus bits it inserts a
// complementary stuff bit and stalls the serializer for that bit time.
module can_stuffing #(
  parameter int unsigned RUN_LENGTH      = 5,
  parameter int unsigned STUFF_CNT_WIDTH = 8
) (
  input  logic                       Clock_TX,
  input  logic                       Reset_N,
  input  logic                       Frame_Start,
  input  logic                       Stuff_Enable,
  input  logic                       Bit_Valid,
  input  logic                       Bit_Input,
  output logic                       Bit_Ready,
  output logic                       Bit_Output,
  output logic                       Stuff_Inserted,
  output logic                       Underflow,
  output logic [STUFF_CNT_WIDTH-1:0] Stuff_Count
);

  localparam int unsigned RUN_W = $clog2(RUN_LENGTH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LENGTH);
  localparam logic [STUFF_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                       last_bit_q, last_bit_d;
  logic [RUN_W-1:0]           run_cnt_q, run_cnt_d;
  logic                       stuff_pending_q, stuff_pending_d;
  logic                       bit_out_q, bit_out_d;
  logic                       stuff_ins_q, stuff_ins_d;
  logic                       underflow_q, underflow_d;
  logic [STUFF_CNT_WIDTH-1:0] stuff_cnt_q, stuff_cnt_d;

  logic [RUN_W-1:0]           run_base;
  logic [STUFF_CNT_WIDTH-1:0] cnt_base;
  logic                       bus_bit;
  logic                       pending_now;

  // A Frame_Start overrides a stale stuff bit so the SOF bit is accepted.
  assign Bit_Ready = ~stuff_pending_q | Frame_Start;

  always_comb begin
    last_bit_d      = last_bit_q;
    run_cnt_d       = run_cnt_q;
    stuff_pending_d = stuff_pending_q;
    bit_out_d       = bit_out_q;
    stuff_ins_d     = stuff_ins_q;
    underflow_d     = underflow_q;
    stuff_cnt_d     = stuff_cnt_q;

    run_base    = Frame_Start ? '0 : run_cnt_q;
    cnt_base    = Frame_Start ? '0 : stuff_cnt_q;
    pending_now = stuff_pending_q & ~Frame_Start;
    bus_bit     = Bit_Valid ? Bit_Input : 1'b1;

    if (pending_now) begin
      // Stuff bit opens the next run, so the run restarts at one.
      bit_out_d       = ~last_bit_q;
      last_bit_d      = ~last_bit_q;
      run_cnt_d       = RUN_W'(1);
      stuff_pending_d = 1'b0;
      stuff_ins_d     = 1'b1;
      underflow_d     = 1'b0;
      stuff_cnt_d     = (cnt_base == CNT_MAX) ? cnt_base
                                              : cnt_base + STUFF_CNT_WIDTH'(1);
    end else begin
      // Missing data puts a recessive fill bit on the bus, counted like a '1'.
      bit_out_d       = bus_bit;
      stuff_ins_d     = 1'b0;
      underflow_d     = ~Bit_Valid & Stuff_Enable;
      stuff_cnt_d     = cnt_base;
      stuff_pending_d = 1'b0;
      if (Stuff_Enable) begin
        last_bit_d = bus_bit;
        if ((bus_bit == last_bit_q) && (run_base != '0)) begin
          run_cnt_d = run_base + RUN_W'(1);
        end else begin
          run_cnt_d = RUN_W'(1);
        end
        stuff_pending_d = (run_cnt_d == RUN_MAX);
      end else begin
        run_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge Clock_TX or negedge Reset_N) begin
    if (!Reset_N) begin
      last_bit_q      <= 1'b1;
      run_cnt_q       <= '0;
      stuff_pending_q <= 1'b0;
      bit_out_q       <= 1'b1;
      stuff_ins_q     <= 1'b0;
      underflow_q     <= 1'b0;
      stuff_cnt_q     <= '0;
    end else begin
      last_bit_q      <= last_bit_d;
      run_cnt_q       <= run_cnt_d;
      stuff_pending_q <= stuff_pending_d;
      bit_out_q       <= bit_out_d;
      stuff_ins_q     <= stuff_ins_d;
      underflow_q     <= underflow_d;
      stuff_cnt_q     <= stuff_cnt_d;
    end
  end

  assign Bit_Output     = bit_out_q;
  assign Stuff_Inserted = stuff_ins_q;
  assign Underflow      = underflow_q;
  assign Stuff_Count    = stuff_cnt_q;

endmodule

// File: tb/tb_can_stuffing.sv
// Self-checking bench for can_stuffing: directed scenarios plus random traffic
// compared against a bus-history model of the stuffing rule.
module tb_can_stuffing;

  localparam int unsigned RL = 5;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          stuff_enable = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_input = 1'b0;
  logic          bit_ready;
  logic          bit_output;
  logic          stuff_inserted;
  logic          underflow;
  logic [CW-1:0] stuff_count;

  can_stuffing #(.RUN_LENGTH(RL), .STUFF_CNT_WIDTH(CW)) dut (
    .Clock_TX      (clk),
    .Reset_N       (rst_n),
    .Frame_Start   (frame_start),
    .Stuff_Enable  (stuff_enable),
    .Bit_Valid     (bit_valid),
    .Bit_Input     (bit_input),
    .Bit_Ready     (bit_ready),
    .Bit_Output    (bit_output),
    .Stuff_Inserted(stuff_inserted),
    .Underflow     (underflow),
    .Stuff_Count   (stuff_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: bus bits of the current stuffable run history, pending flag, count.
  bit          hist[$];
  bit          m_pend = 1'b0;
  logic [CW-1:0] m_cnt = '0;
  bit          out_log[$];

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int trailing_equal();
    int n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == hist[hist.size() - 1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_pend = 1'b0;
    m_cnt  = '0;
  endtask

  // One bit time: drive at negedge, check Bit_Ready, clock, check outputs.
  task automatic step(input bit fs, input bit en, input bit v, input bit b, output bit took);
    bit e_out, e_ins, e_unf, bb;
    @(negedge clk);
    frame_start  = fs;
    stuff_enable = en;
    bit_valid    = v;
    bit_input    = b;
    #1;
    chk("bit_ready", CW'(bit_ready), CW'(!m_pend || fs));
    took = v && (!m_pend || fs);
    if (fs) model_reset();
    if (m_pend) begin
      e_out = !hist[hist.size() - 1];
      hist.delete();
      hist.push_back(e_out);
      e_ins = 1'b1;
      e_unf = 1'b0;
      if (m_cnt != '1) m_cnt = m_cnt + CW'(1);
      m_pend = 1'b0;
    end else begin
      bb    = v ? b : 1'b1;
      e_out = bb;
      e_ins = 1'b0;
      e_unf = !v && en;
      if (en) begin
        hist.push_back(bb);
        if (hist.size() > RL) void'(hist.pop_front());
        if (trailing_equal() == RL) m_pend = 1'b1;
      end else begin
        hist.delete();
      end
    end
    @(posedge clk);
    #1;
    chk("bit_output", CW'(bit_output), CW'(e_out));
    chk("stuff_inserted", CW'(stuff_inserted), CW'(e_ins));
    chk("underflow", CW'(underflow), CW'(e_unf));
    chk("stuff_count", stuff_count, m_cnt);
    out_log.push_back(bit_output);
  endtask

  // Serializer behaviour: hold the bit until it is consumed.
  task automatic send(input bit fs, input bit en, input bit b);
    bit took = 1'b0;
    int tries = 0;
    while (!took && tries < 3) begin
      step(fs, en, 1'b1, b, took);
      fs = 1'b0;
      tries++;
    end
    if (!took) begin
      checks++;
      fails++;
      $error("FAIL send_timeout: observed not consumed expected consumed");
    end
  endtask

  task automatic check_log(input string tag, input bit exp[]);
    chk({tag, "_len"}, CW'(out_log.size()), CW'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      chk(tag, CW'(out_log[i]), CW'(exp[i]));
  endtask

  initial begin
    bit took;
    bit prev_b;
    bit exp_basic[];
    bit exp_chain[];
    bit exp_crc[];
    bit exp_unf[];
    exp_basic = '{0, 0, 0, 0, 0, 1, 1, 1};
    exp_chain = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    exp_crc   = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    exp_unf   = '{0, 0, 0, 1, 1, 1, 1, 1, 0, 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bit_output", CW'(bit_output), CW'(1));
    chk("rst_stuff_inserted", CW'(stuff_inserted), CW'(0));
    chk("rst_underflow", CW'(underflow), CW'(0));
    chk("rst_stuff_count", stuff_count, CW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Idle after reset
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, took);

    // Basic stuff
    out_log.delete();
    send(1'b1, 1'b1, 1'b0);
    repeat (4) send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b1);
    check_log("basic_seq", exp_basic);
    chk("basic_count", stuff_count, CW'(1));

    // Chained stuff
    out_log.delete();
    send(1'b1, 1'b1, 1'b1);
    repeat (4) send(1'b0, 1'b1, 1'b1);
    repeat (5) send(1'b0, 1'b1, 1'b0);
    check_log("chain_seq", exp_chain);
    chk("chain_count", stuff_count, CW'(2));

    // Disabled: no stuffing, count held
    repeat (10) send(1'b0, 1'b0, 1'b0);
    chk("disabled_count", stuff_count, CW'(2));

    // End of CRC: enable drops while a stuff bit is pending
    out_log.delete();
    send(1'b1, 1'b1, 1'b1);
    repeat (4) send(1'b0, 1'b1, 1'b1);
    repeat (6) send(1'b0, 1'b0, 1'b1);
    check_log("crc_seq", exp_crc);
    chk("crc_count", stuff_count, CW'(1));

    // Underflow fill bit counts toward the run
    out_log.delete();
    send(1'b1, 1'b1, 1'b0);
    repeat (2) send(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, took);
    chk("unf_flag", CW'(underflow), CW'(1));
    repeat (4) send(1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b0);
    check_log("unf_seq", exp_unf);

    // Frame_Start concurrent with a pending stuff bit drops it
    send(1'b1, 1'b1, 1'b0);
    repeat (4) send(1'b0, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    chk("fs_drop_count", stuff_count, CW'(0));

    // Reset mid-run with a stuff bit pending
    repeat (4) send(1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_bit_output", CW'(bit_output), CW'(1));
    chk("midrst_stuff_inserted", CW'(stuff_inserted), CW'(0));
    chk("midrst_underflow", CW'(underflow), CW'(0));
    chk("midrst_stuff_count", stuff_count, CW'(0));
    chk("midrst_ready", CW'(bit_ready), CW'(1));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, took);

    // Saturation of the stuff counter
    send(1'b1, 1'b1, 1'b0);
    repeat (1700) send(1'b0, 1'b1, 1'b0);
    chk("sat_count", stuff_count, CW'(8'hFF));

    // Random traffic
    prev_b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      bit fs, en, v, b;
      fs = ($urandom_range(0, 39) == 0);
      en = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 7) != 0);
      b  = ($urandom_range(0, 4) == 0) ? !prev_b : prev_b;
      prev_b = b;
      step(fs, en, v, b, took);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
